// File: rtl/spi_nor_flash_responder.sv
// SPI NOR flash target model: oversamples a mode-0 SPI bus on s_clock and
// answers the controller's command set from an internal byte array.
// Assumes MEM_ADDR_W >= 8 (at least one full 256-byte page).
module spi_nor_flash_responder #(
  parameter int          MEM_ADDR_W = 12,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
  parameter logic [7:0]  CFG_REG    = 8'h02,
  parameter int          PP_BUSY    = 512,
  parameter int          PE_BUSY    = 1024
) (
  input  logic       s_clock,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       wel,
  output logic       wip,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       cmd_reject
);

  localparam int DEPTH    = 1 << MEM_ADDR_W;
  localparam int BUSY_MAX = (PP_BUSY > PE_BUSY) ? PP_BUSY : PE_BUSY;
  localparam int BW       = $clog2(BUSY_MAX + 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA_OUT, DATA_IN, IGNORE} state_t;

  // Array powers up erased; reset deliberately leaves it untouched.
  logic [7:0] mem [0:DEPTH-1] = '{default: 8'hFF};

  logic [1:0] csSync, sckSync, mosiSync;
  logic       csPrev, sckPrev;
  logic       csRise, csFall, sckRise, sckFall, mosiBit;

  state_t                state;
  logic [2:0]            bitCnt;
  logic [3:0]            byteCnt;
  logic [1:0]            outCnt;
  logic [6:0]            shiftIn;
  logic [7:0]            byteIn;
  logic [7:0]            opcode;
  logic [MEM_ADDR_W-1:0] addrSh, addrNext, addr;
  logic                  pendWren, pendWrdi, pendPp, pendPe, ppWritten;
  logic [6:0]            txSh;
  logic [7:0]            txByte;
  logic [BW-1:0]         busyCnt;
  logic                  eraseOn;
  logic [MEM_ADDR_W-1:0] eraseAddr;
  logic                  spiWe;
  logic [MEM_ADDR_W-1:0] spiWa;
  logic [7:0]            spiWd;
  logic                  memWe;
  logic [MEM_ADDR_W-1:0] memA;
  logic [7:0]            memWd, memRdata;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge s_clock) begin
    if (reset) begin
      csSync   <= 2'b11;
      sckSync  <= 2'b00;
      mosiSync <= 2'b00;
      csPrev   <= 1'b1;
      sckPrev  <= 1'b0;
    end else begin
      csSync   <= {csSync[0], cs_n};
      sckSync  <= {sckSync[0], sck};
      mosiSync <= {mosiSync[0], mosi};
      csPrev   <= csSync[1];
      sckPrev  <= sckSync[1];
    end
  end

  assign csFall   = csPrev & ~csSync[1];
  assign csRise   = ~csPrev & csSync[1];
  assign sckRise  = sckSync[1] & ~sckPrev & ~csSync[1];
  assign sckFall  = ~sckSync[1] & sckPrev & ~csSync[1];
  assign mosiBit  = mosiSync[1];
  assign byteIn   = {shiftIn, mosiBit};
  assign addrNext = {addrSh[MEM_ADDR_W-2:0], mosiBit};

  // Response byte selected at each output byte boundary; status is live.
  always_comb begin
    txByte = memRdata;
    case (opcode)
      8'h05: txByte = {6'b0, wel, wip};
      8'h15: txByte = CFG_REG;
      8'h9F: begin
        case (outCnt)
          2'd0:    txByte = JEDEC_ID[23:16];
          2'd1:    txByte = JEDEC_ID[15:8];
          2'd2:    txByte = JEDEC_ID[7:0];
          default: txByte = 8'h00;
        endcase
      end
      default: txByte = memRdata;
    endcase
  end

  // Single memory port: erase engine, then SPI page-program, else read address.
  always_comb begin
    memWe = eraseOn | spiWe;
    memWd = eraseOn ? 8'hFF : spiWd;
    memA  = eraseOn ? eraseAddr : (spiWe ? spiWa : addr);
  end

  // Byte-wide single-port array with registered read (read data always tracks memA).
  always_ff @(posedge s_clock) begin
    if (memWe) mem[memA] <= memWd;
    memRdata <= mem[memA];
  end

  // Command FSM, status register, busy timer and erase sequencer.
  always_ff @(posedge s_clock) begin
    if (reset) begin
      state      <= IDLE;
      bitCnt     <= '0;
      byteCnt    <= '0;
      outCnt     <= '0;
      shiftIn    <= '0;
      opcode     <= '0;
      addrSh     <= '0;
      addr       <= '0;
      pendWren   <= 1'b0;
      pendWrdi   <= 1'b0;
      pendPp     <= 1'b0;
      pendPe     <= 1'b0;
      ppWritten  <= 1'b0;
      txSh       <= '0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      wel        <= 1'b0;
      wip        <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_code   <= '0;
      cmd_reject <= 1'b0;
      busyCnt    <= '0;
      eraseOn    <= 1'b0;
      eraseAddr  <= '0;
      spiWe      <= 1'b0;
      spiWa      <= '0;
      spiWd      <= '0;
    end else begin
      cmd_valid  <= 1'b0;
      cmd_reject <= 1'b0;
      spiWe      <= 1'b0;

      // Busy completion drops both WIP and WEL.
      if (busyCnt != '0) begin
        busyCnt <= busyCnt - BW'(1);
        if (busyCnt == BW'(1)) begin
          wip <= 1'b0;
          wel <= 1'b0;
        end
      end

      if (eraseOn) begin
        eraseAddr[7:0] <= eraseAddr[7:0] + 8'd1;
        if (eraseAddr[7:0] == 8'hFF) eraseOn <= 1'b0;
      end

      if (csRise) begin
        // End of transaction: commit only exactly-framed actions.
        state   <= IDLE;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
        if (pendWren && byteCnt == 4'd1) wel <= 1'b1;
        if (pendWrdi && byteCnt == 4'd1) wel <= 1'b0;
        if (pendPp && ppWritten) begin
          wip     <= 1'b1;
          busyCnt <= BW'(PP_BUSY);
        end
        if (pendPe && byteCnt == 4'd4) begin
          wip            <= 1'b1;
          busyCnt        <= BW'(PE_BUSY);
          eraseOn        <= 1'b1;
          eraseAddr      <= addrSh;
          eraseAddr[7:0] <= 8'h00;
        end
        pendWren <= 1'b0;
        pendWrdi <= 1'b0;
        pendPp   <= 1'b0;
        pendPe   <= 1'b0;
      end else if (csFall) begin
        state     <= CMD;
        bitCnt    <= '0;
        byteCnt   <= '0;
        outCnt    <= '0;
        ppWritten <= 1'b0;
        pendWren  <= 1'b0;
        pendWrdi  <= 1'b0;
        pendPp    <= 1'b0;
        pendPe    <= 1'b0;
      end else if (state != IDLE) begin
        if (sckRise) begin
          shiftIn <= byteIn[6:0];
          bitCnt  <= bitCnt + 3'd1;
          if (state == ADDR) addrSh <= addrNext;
          if (bitCnt == 3'd7) begin
            if (byteCnt != 4'hF) byteCnt <= byteCnt + 4'd1;
            case (state)
              CMD: begin
                cmd_valid <= 1'b1;
                cmd_code  <= byteIn;
                opcode    <= byteIn;
                if (wip && byteIn != 8'h05) begin
                  state      <= IGNORE;
                  cmd_reject <= 1'b1;
                end else begin
                  case (byteIn)
                    8'h06: begin pendWren <= 1'b1; state <= IGNORE; end
                    8'h04: begin pendWrdi <= 1'b1; state <= IGNORE; end
                    8'h05, 8'h15, 8'h9F: state <= DATA_OUT;
                    8'h03, 8'h0B: state <= ADDR;
                    8'h02, 8'h81: begin
                      if (wel) begin
                        state    <= ADDR;
                        pendPp   <= (byteIn == 8'h02);
                        pendPe   <= (byteIn == 8'h81);
                      end else begin
                        state      <= IGNORE;
                        cmd_reject <= 1'b1;
                      end
                    end
                    default: begin
                      state      <= IGNORE;
                      cmd_reject <= 1'b1;
                    end
                  endcase
                end
              end
              ADDR: begin
                if (byteCnt == 4'd3) begin
                  addr <= addrNext;
                  case (opcode)
                    8'h03:   state <= DATA_OUT;
                    8'h0B:   state <= DUMMY;
                    8'h02:   state <= DATA_IN;
                    default: state <= IGNORE;
                  endcase
                end
              end
              DUMMY: state <= DATA_OUT;
              DATA_OUT: begin
                // Advance now so the next byte is prefetched before its first fall.
                addr <= addr + MEM_ADDR_W'(1);
                if (outCnt != 2'd3) outCnt <= outCnt + 2'd1;
              end
              DATA_IN: begin
                spiWe      <= 1'b1;
                spiWa      <= addr;
                spiWd      <= byteIn;
                addr[7:0]  <= addr[7:0] + 8'd1;
                ppWritten  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        if (sckFall && state == DATA_OUT) begin
          if (bitCnt == 3'd0) begin
            miso    <= txByte[7];
            txSh    <= txByte[6:0];
            miso_oe <= 1'b1;
          end else begin
            miso <= txSh[6];
            txSh <= {txSh[5:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_nor_flash_responder.sv
// Directed bench: SPI master tasks push expected responses into queues; monitor
// processes pop and compare when the responder presents MISO bytes, command
// pulses, or ends a WIP busy window.
module tb_spi_nor_flash_responder;

  localparam int PP_B = 512;
  localparam int PE_B = 1024;

  logic       s_clock = 1'b0;
  logic       reset   = 1'b1;
  logic       cs_n    = 1'b1;
  logic       sck     = 1'b0;
  logic       mosi    = 1'b0;
  logic       miso, miso_oe, wel, wip, cmd_valid, cmd_reject;
  logic [7:0] cmd_code;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] code;
    logic       rej;
  } cmd_t;

  cmd_t       expCmd[$];
  logic [7:0] expMiso[$];
  int         expWip[$];

  spi_nor_flash_responder #(
    .MEM_ADDR_W(12), .JEDEC_ID(24'hEF4016), .CFG_REG(8'h02),
    .PP_BUSY(PP_B), .PE_BUSY(PE_B)
  ) dut (
    .s_clock(s_clock), .reset(reset), .cs_n(cs_n), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .wel(wel), .wip(wip),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_reject(cmd_reject)
  );

  always #5 s_clock = ~s_clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge s_clock);
  endtask

  task automatic sendBits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      cyc(4);
      sck = 1'b1;
      cyc(4);
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] b);
    sendBits(b, 8);
  endtask

  task automatic csLo();
    cs_n = 1'b0;
    cyc(4);
  endtask

  task automatic csHi();
    cyc(4);
    cs_n = 1'b1;
    mosi = 1'b0;
    cyc(8);
  endtask

  task automatic pushCmd(input logic [7:0] c, input logic r);
    cmd_t e;
    e.code = c;
    e.rej  = r;
    expCmd.push_back(e);
  endtask

  task automatic simpleCmd(input logic [7:0] c, input logic r);
    pushCmd(c, r);
    csLo(); xfer(c); csHi();
  endtask

  task automatic rdsr(input logic [7:0] exp);
    pushCmd(8'h05, 1'b0);
    expMiso.push_back(exp);
    csLo(); xfer(8'h05); xfer(8'h00); csHi();
  endtask

  task automatic readMem(input logic [23:0] a, input logic [7:0] exp[$]);
    pushCmd(8'h03, 1'b0);
    foreach (exp[i]) expMiso.push_back(exp[i]);
    csLo(); xfer(8'h03); xfer(a[23:16]); xfer(a[15:8]); xfer(a[7:0]);
    foreach (exp[i]) xfer(8'h00);
    csHi();
  endtask

  task automatic waitIdle(input string name, input int maxCyc);
    int n;
    n = 0;
    while (wip && n < maxCyc) begin
      cyc(1);
      n++;
    end
    checks++;
    if (wip) begin
      failures++;
      $display("FAIL %s: wip still 1 after %0d cycles, expected 0", name, maxCyc);
    end
  endtask

  // MISO byte monitor: collects bits on the master's sampling edge.
  int         rxCnt = 0;
  logic [7:0] rxSh  = '0;
  always @(negedge cs_n) rxCnt = 0;
  always @(posedge sck) begin
    if (!cs_n && miso_oe) begin
      rxSh = {rxSh[6:0], miso};
      rxCnt++;
      if (rxCnt == 8) begin
        rxCnt = 0;
        checks++;
        if (expMiso.size() == 0) begin
          failures++;
          $display("FAIL miso_byte: got unexpected %02h expected none", rxSh);
        end else begin
          logic [7:0] e;
          e = expMiso.pop_front();
          if (rxSh !== e) begin
            failures++;
            $display("FAIL miso_byte: got %02h expected %02h", rxSh, e);
          end
        end
      end
    end
  end

  // Command-pulse monitor.
  always @(negedge s_clock) begin
    if (!reset && (cmd_valid || cmd_reject)) begin
      checks++;
      if (!cmd_valid || expCmd.size() == 0) begin
        failures++;
        $display("FAIL cmd_pulse: got valid=%0b code=%02h rej=%0b expected none",
                 cmd_valid, cmd_code, cmd_reject);
      end else begin
        cmd_t e;
        e = expCmd.pop_front();
        if (cmd_code !== e.code || cmd_reject !== e.rej) begin
          failures++;
          $display("FAIL cmd_pulse: got code=%02h rej=%0b expected code=%02h rej=%0b",
                   cmd_code, cmd_reject, e.code, e.rej);
        end
      end
    end
  end

  // WIP window monitor: length of each busy period outside reset.
  int wipRun = 0;
  always @(negedge s_clock) begin
    if (wip) wipRun++;
    else if (wipRun > 0) begin
      if (!reset) begin
        checks++;
        if (expWip.size() == 0) begin
          failures++;
          $display("FAIL wip_len: got %0d expected no busy period", wipRun);
        end else begin
          int e;
          e = expWip.pop_front();
          if (wipRun != e) begin
            failures++;
            $display("FAIL wip_len: got %0d expected %0d", wipRun, e);
          end
        end
      end
      wipRun = 0;
    end
  end

  initial begin
    logic [7:0] v[$];

    cyc(4);
    reset = 1'b0;
    cyc(2);
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_wel", wel, 0);
    chk("rst_wip", wip, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_code", cmd_code, 0);
    chk("rst_cmd_reject", cmd_reject, 0);

    // RDID: three ID bytes then zeros.
    pushCmd(8'h9F, 1'b0);
    expMiso.push_back(8'hEF); expMiso.push_back(8'h40); expMiso.push_back(8'h16);
    expMiso.push_back(8'h00); expMiso.push_back(8'h00);
    csLo(); xfer(8'h9F); repeat (5) xfer(8'h00); csHi();

    // RDCR.
    pushCmd(8'h15, 1'b0);
    expMiso.push_back(8'h02); expMiso.push_back(8'h02);
    csLo(); xfer(8'h15); xfer(8'h00); xfer(8'h00); csHi();

    // cs_n pulse without clocks changes nothing.
    csLo(); csHi();
    chk("cs_only_wel", wel, 0);

    // WREN / WRDI with status reads.
    simpleCmd(8'h06, 1'b0);
    chk("wren_wel", wel, 1);
    rdsr(8'h02);
    simpleCmd(8'h04, 1'b0);
    chk("wrdi_wel", wel, 0);
    rdsr(8'h00);

    // Unknown opcode rejected.
    simpleCmd(8'hAB, 1'b1);

    // Page program wrapping inside the page.
    simpleCmd(8'h06, 1'b0);
    pushCmd(8'h02, 1'b0);
    expWip.push_back(PP_B);
    csLo(); xfer(8'h02); xfer(8'h00); xfer(8'h0A); xfer(8'hFE);
    xfer(8'h11); xfer(8'h22); xfer(8'h33); csHi();
    chk("pp_wip", wip, 1);
    rdsr(8'h03);
    simpleCmd(8'h06, 1'b1);  // rejected while busy
    waitIdle("pp_busy", 2000);
    chk("pp_done_wel", wel, 0);
    rdsr(8'h00);
    v = '{8'h11, 8'h22};
    readMem(24'h000AFE, v);
    pushCmd(8'h0B, 1'b0);
    expMiso.push_back(8'h33);
    csLo(); xfer(8'h0B); xfer(8'h00); xfer(8'h0A); xfer(8'h00); xfer(8'h00); xfer(8'h00); csHi();

    // PP without WREN: rejected, memory untouched.
    pushCmd(8'h02, 1'b1);
    csLo(); xfer(8'h02); xfer(8'h00); xfer(8'h0B); xfer(8'h00); xfer(8'hAA); csHi();
    chk("pp_rej_wip", wip, 0);
    v = '{8'hFF};
    readMem(24'h000B00, v);

    // Page erase of the page holding 0x0A01.
    simpleCmd(8'h06, 1'b0);
    pushCmd(8'h81, 1'b0);
    expWip.push_back(PE_B);
    csLo(); xfer(8'h81); xfer(8'h00); xfer(8'h0A); xfer(8'h01); csHi();
    chk("pe_wip", wip, 1);
    waitIdle("pe_busy", 3000);
    v = {};
    for (int i = 0; i < 256; i++) v.push_back(8'hFF);
    readMem(24'h000A00, v);

    // Read wraps at the top of the array; upper address bits ignored.
    simpleCmd(8'h06, 1'b0);
    pushCmd(8'h02, 1'b0);
    expWip.push_back(PP_B);
    csLo(); xfer(8'h02); xfer(8'h00); xfer(8'h00); xfer(8'h00); xfer(8'h5A); csHi();
    waitIdle("pp2_busy", 2000);
    v = '{8'hFF, 8'h5A};
    readMem(24'h00FFFF, v);

    // Truncated WREN (5 bits) leaves WEL clear.
    csLo(); sendBits(8'h06, 5); csHi();
    chk("partial_wren_wel", wel, 0);

    // Reset in the middle of an erase.
    simpleCmd(8'h06, 1'b0);
    pushCmd(8'h81, 1'b0);
    csLo(); xfer(8'h81); xfer(8'h00); xfer(8'h00); xfer(8'h00); csHi();
    chk("pe2_wip", wip, 1);
    cyc(100);
    reset = 1'b1;
    cyc(1);
    chk("rst_mid_wip", wip, 0);
    chk("rst_mid_wel", wel, 0);
    cyc(1);
    reset = 1'b0;
    cyc(4);
    rdsr(8'h00);
    v = '{8'hFF};
    readMem(24'h000000, v);

    cyc(20);
    chk("miso_queue_empty", expMiso.size(), 0);
    chk("cmd_queue_empty", expCmd.size(), 0);
    chk("wip_queue_empty", expWip.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_nor_flash_responder.md
# spi_nor_flash_responder

Synthesizable SPI NOR flash target that emulates the serial flash device on the far side of the team's SPI flash controller. It samples the controller's CS_n/MCLK/MOSI with `s_clock`, decodes the same command set the controller issues, and answers on MISO from an internal block-RAM array. It supports on-FPGA loopback testing and simulation of the controller without a physical flash part.

## Interface
- `MEM_ADDR_W`, 12: array size is 2^MEM_ADDR_W bytes. Only the low MEM_ADDR_W bits of the 24-bit address are used.
- `JEDEC_ID`, 24'hEF4016: RDID response, MSB first.
- `CFG_REG`, 8'h02: RDCR response.
- `PP_BUSY`, 512: s_clock cycles WIP stays high after a page program.
- `PE_BUSY`, 1024: s_clock cycles WIP stays high after a page erase. Must be ≥ 256.
- `s_clock` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cs_n` in 1: chip select from the controller, asynchronous.
- `sck` in 1: SPI clock, mode 0, asynchronous.
- `mosi` in 1: serial data in, asynchronous.
- `miso` out 1: serial data out, registered.
- `miso_oe` out 1: high while the block drives a response byte.
- `wel` out 1: write-enable latch.
- `wip` out 1: write/erase in progress.
- `cmd_valid` out 1: one-cycle pulse when an opcode byte is complete.
- `cmd_code` out 8: last opcode, valid with `cmd_valid`.
- `cmd_reject` out 1: one-cycle pulse when a command is ignored (busy, WEL clear, or unknown opcode).

## Operation
- Input synchronization:
  - cs_n, sck and mosi each pass through a 2-FF synchronizer.
  - Edge detect on the synchronized sck.
  - mosi is sampled on the sck rise; miso updates on the sck fall.
- A cs_n fall clears the bit and byte counters and enters CMD.
- A cs_n rise returns to IDLE from any state. A partial byte is discarded. Pending WREN/WRDI/PP/PE actions are committed only if the byte count is exact.
- FSM states: IDLE, CMD, ADDR (3 bytes, MSB first), DUMMY (8 clocks), DATA_OUT, DATA_IN, IGNORE.
- Opcodes:
  - 06 WREN: sets WEL at cs_n rise, only if exactly 1 byte was received.
  - 04 WRDI: clears WEL at cs_n rise, same condition.
  - 05 RDSR: DATA_OUT, repeating {6'b0, wel, wip}. The value is re-sampled at each byte boundary.
  - 15 RDCR: DATA_OUT, repeating CFG_REG.
  - 9F RDID: 3 ID bytes, then 0x00 for all later bytes.
  - 03 READ: ADDR → DATA_OUT.
  - 0B FREAD: ADDR → DUMMY → DATA_OUT.
  - Reads auto-increment the address and wrap at 2^MEM_ADDR_W.
  - 02 PP: ADDR → DATA_IN.
    - Each complete byte is written to mem[{addr[hi:8], (addr[7:0]+n) mod 256}], wrapping within the 256-byte page. Data overwrites the old byte; no AND with existing contents.
    - At cs_n rise, if ≥1 data byte was written: wip=1 for PP_BUSY cycles.
  - 81 PE: ADDR only.
    - At cs_n rise after exactly 4 bytes, the erase engine writes 0xFF to the 256 bytes of the addressed page, one per cycle.
    - wip=1 for PE_BUSY cycles.
- PP/PE with WEL clear: the command enters IGNORE and raises cmd_reject. Memory is not modified.
- Busy completion clears both WIP and WEL.
- While WIP=1, every opcode except 05 goes to IGNORE with cmd_reject.
- Unknown opcodes go to IGNORE with cmd_reject.
- In IGNORE: miso_oe=0 and miso=0 until cs_n rises.
- The memory array has a single port, shared by the SPI path and the erase engine. The two never overlap because WIP blocks PP and PE.
- Memory is not cleared by reset. Power-up contents are all 0xFF.

## Timing
- SCK high and low times must each be ≥ 4 s_clock cycles, so SCK ≤ s_clock/8.
- sck fall to miso change: 3 s_clock cycles (2 sync + 1 register).
- The first response bit (MSB) is driven after the SCK fall that follows the last command, address, or dummy bit.
- Read data is prefetched from BRAM at least 4 cycles before it is needed: on the 8th rising edge of the preceding byte.
- cmd_valid/cmd_code: valid 1 cycle after the synchronized 8th rising edge of the opcode.
- WEL/WIP set: 1 cycle after the synchronized cs_n rise.
- WIP falls exactly PP_BUSY or PE_BUSY cycles after it was set; WEL falls in the same cycle.
- Reset values: miso=0, miso_oe=0, wel=0, wip=0, cmd_valid=0, cmd_code=0, cmd_reject=0, FSM=IDLE, busy counter=0.
- Reset mid-command or mid-erase: the busy engine and FSM return to idle. Already written or erased bytes stay modified. The remainder of an erased page is left as-is.
- cs_n asserted without SCK, then released: no state change.

## Test plan
- RDID at SCK = s_clock/8 → MISO bytes EF, 40, 16, then 00. cmd_valid with cmd_code=9F.
- WREN, then RDSR → 0x02. WRDI, then RDSR → 0x00.
- WREN; PP at 0x000AFE with data 11, 22, 33; RDSR shows 0x03 during busy, then 0x00 after PP_BUSY cycles; READ at 0x000AFE → 11, 22. Data byte 33 wraps to page offset 0: FREAD at 0x000A00 → 33.
- PP without WREN → cmd_reject pulse; READ returns FF.
- WREN; PE at 0x000A01; after WIP clears, READ of 0x000A00–0x000AFF → all FF.
- cs_n raised after 5 bits of WREN → WEL stays 0.
- Reset asserted during erase → wip=0 and wel=0 next cycle; RDSR → 0x00.
